mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Round-robin arbiter that shares one `simple_mem` word-memory port between `NUM_REQ` requesters, such as the I-cache and D-cache refill/writeback engines. It accepts one transaction at a time from a per-requester valid/ready request channel and drives the single-cycle `mem_req` pulse. It then waits for `mem_ready` and returns a one-cycle response to the granted requester. Only one memory transaction is outstanding at any time.

## Interface
- `NUM_REQ`, default 2: number of requesters, minimum 2.
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-port request valid.
- `req_we` in NUM_REQ: per-port write enable.
- `req_addr` in NUM_REQ*ADDR_WIDTH: port i is at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata` in NUM_REQ*DATA_WIDTH: port i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out NUM_REQ: one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `resp_valid` out NUM_REQ: one-cycle completion pulse to the owning port.
- `resp_rdata` out DATA_WIDTH: read data, shared by all ports, qualified by `resp_valid`.
- `mem_req` out 1: one-cycle memory request pulse.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_rdata` in DATA_WIDTH: memory read data, valid with `mem_ready`.
- `mem_ready` in 1: memory completion.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `mem_req` is high for exactly one cycle.
  - WAIT: hold until `mem_ready`.
  - RESP: pulse `resp_valid`.
- IDLE:
  - `req_ready` is the round-robin one-hot winner among `req_valid`; it is all zero when no port is valid.
  - `req_ready` is combinational and is forced to zero outside IDLE.
  - On a handshake: latch `we`, `addr` and `wdata` into the `mem_*` registers, record the owner, and go to ISSUE.
- ISSUE: `mem_req`=1, then go to WAIT unconditionally.
- WAIT:
  - On `mem_ready`, capture `mem_rdata` for reads, or zero for writes, into `resp_rdata`, then go to RESP.
  - There is no timeout; slower memories are tolerated.
- RESP: `resp_valid[owner]`=1 for one cycle, then go to IDLE.
- Round-robin pointer `last`:
  - Priority order is `last+1, last+2, ...` modulo `NUM_REQ`.
  - `last` updates to the winner on the handshake only.
  - Reset value is `NUM_REQ-1`, so port 0 wins first.
- `mem_ready` in IDLE, ISSUE or RESP is ignored and never produces a response.
- A requester may drop `req_valid` before it is granted without penalty. Request fields are sampled only at the handshake.
- `mem_addr` and `mem_we` hold their latched values until the next handshake.
- Reset, including mid-transaction:
  - State returns to IDLE; `last`=`NUM_REQ-1`.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `resp_valid` and `resp_rdata` are all cleared to 0.
  - The in-flight transaction is dropped with no response. A write already presented to memory may have completed.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: ISSUE, `mem_req`=1.
- Cycle 2: WAIT; `simple_mem` asserts `mem_ready`.
- Cycle 3: RESP, `resp_valid`=1.
- Cycle 4: IDLE; the next handshake is possible.
- Best-case latency is 3 cycles from handshake to `resp_valid`. Peak throughput is one transaction per 4 cycles.
- Each extra cycle of memory latency adds one WAIT cycle.
- All outputs except `req_ready` and `busy` are registered.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - a function `rr_next(valid, last)` returning the one-hot winner.
- Sub-module `rr_arbiter` contains the parameterized `NUM_REQ` round-robin grant logic and the pointer, with an update strobe.
- Top level contains the FSM, the `mem_*` registers and response steering.

## Test plan
- Single read: preload `mem[4]`=`32'hDEADBEEF`; port 1 reads addr `0x10`.
  - Response: `req_ready[1]` at cycle 0, `mem_req` at cycle 1, `resp_valid`=`2'b10` with `resp_rdata`=`DEADBEEF` at cycle 3.
- Write then read: port 0 writes `0x20`←`32'hA5A5_0001`, then reads `0x20`.
  - Response: write has `resp_rdata`=0; read returns `A5A50001`.
- Fairness: both ports hold `req_valid` for 4 transactions from reset.
  - Response: grant order is 0,1,0,1; no port gets two consecutive grants.
- Back-to-back: port 0 keeps `req_valid` high alone.
  - Response: handshakes every 4 cycles; `mem_req` is never high for two consecutive cycles.
- Stalled memory: model holds `mem_ready` off 5 extra cycles; spurious `mem_ready` in IDLE.
  - Response: `resp_valid` at cycle 8; no response from the spurious pulse.
- Reset mid-WAIT: assert `rst_n`=0 asynchronously during cycle 2.
  - Response: all registered outputs 0 immediately; no `resp_valid`; port 0 wins first after release.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and the round-robin winner function for mem_rr_arbiter.
package mem_arb_pkg;

  // Widest requester vector rr_next can handle.
  localparam int unsigned MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // One-hot winner among valid, searching last+1, last+2, ... modulo num.
  // Returns all zero when nothing is valid.
  function automatic logic [MAX_REQ-1:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                                 input int unsigned        last,
                                                 input int unsigned        num);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= num; k++) begin
      idx = (last + k) % num;
      if (!found && valid[idx[4:0]]) begin
        grant[idx[4:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_arbiter.sv
// Round-robin grant logic with the last-winner pointer, advanced by an update strobe.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0]   last_q, last_d;
  logic [MAX_REQ-1:0] grant_wide;

  // Winner selection and its binary index.
  always_comb begin
    grant_wide = rr_next(MAX_REQ'(valid), 32'(last_q), NUM_REQ);
    grant      = grant_wide[NUM_REQ-1:0];
    grant_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  if (NUM_REQ < MAX_REQ) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^grant_wide[MAX_REQ-1:NUM_REQ];
  end

  // Pointer moves to the winner only when the handshake happens.
  always_comb begin
    last_d = update ? grant_idx : last_q;
  end

  // Pointer register; reset makes port 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDX_W'(NUM_REQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one simple_mem port among NUM_REQ requesters,
// one outstanding transaction at a time.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   hs;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .update    (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is only offered while idle; pick the winner's request fields.
  always_comb begin
    req_ready = (state_q == IDLE) ? grant : '0;
    hs        = |(req_valid & req_ready);
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM next state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    owner_d      = owner_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          owner_d     = grant_idx;
          mem_req_d   = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready) begin
          resp_rdata_d          = mem_we_q ? '0 : mem_rdata;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      owner_q      <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      owner_q      <= owner_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a small simple_mem model.
module tb_mem_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_ready;
  logic            busy;

  int tests = 0;
  int fails = 0;

  mem_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // simple_mem model: ready one cycle after mem_req plus extra_lat stall cycles.
  logic [31:0] mem [64];
  int          extra_lat = 0;
  logic        mem_ready_m = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic        spur = 1'b0;
  assign mem_ready = mem_ready_m | spur;

  always @(posedge clk) begin
    mem_ready_m <= 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        mem_ready_m <= 1'b1;
        pend        <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (mem_req) begin
      if (mem_we) begin
        mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata          <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
      if (extra_lat == 0) mem_ready_m <= 1'b1;
      else begin
        pend <= 1'b1;
        cnt  <= extra_lat - 1;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    req_valid[p]           = v;
    req_we[p]              = we;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*DW +: DW]  = d;
  endtask

  task automatic drain;
    for (int g = 0; g < 30; g++) begin
      if (!busy) break;
      step();
    end
  endtask

  // One transaction on port p; cyc is cycles from handshake to resp_valid (-1 if none).
  task automatic run_txn(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic [1:0] rv, output int cyc);
    logic granted;
    cyc = -1; rd = '0; rv = '0; granted = 1'b0;
    set_port(p, 1'b1, we, a, d);
    for (int g = 0; g < 50; g++) begin
      #1;
      if (req_ready[p]) begin
        granted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (granted) begin
      step();
      req_valid[p] = 1'b0;
      for (int k = 1; k < 60; k++) begin
        if (resp_valid != '0) begin
          cyc = k; rv = resp_valid; rd = resp_rdata;
          break;
        end
        step();
      end
      step();
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h rv=%b rd=%h, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata);
    end
    tests++;
    if (busy !== 1'b0 || req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b ready=%b, want 0 00", busy, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read;
    set_port(1, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++; $display("FAIL read_grant: got %b want 10", req_ready);
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
      fails++;
      $display("FAIL read_issue: got req=%b addr=%h we=%b busy=%b ready=%b, want 1 10 0 1 00",
               mem_req, mem_addr, mem_we, busy, req_ready);
    end
    step();
    tests++;
    if (mem_req !== 1'b0 || resp_valid !== 2'b00) begin
      fails++; $display("FAIL read_wait: got req=%b rv=%b, want 0 00", mem_req, resp_valid);
    end
    step();
    tests++;
    if (resp_valid !== 2'b10 || resp_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL read_resp: got rv=%b rd=%h, want 10 deadbeef", resp_valid, resp_rdata);
    end
    step();
    tests++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      fails++; $display("FAIL read_done: got rv=%b busy=%b, want 00 0", resp_valid, busy);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic [1:0] rv; int cyc;
    run_txn(0, 1'b1, 32'h20, 32'hA5A5_0001, rd, rv, cyc);
    tests++;
    if (rv !== 2'b01 || rd !== 32'h0 || cyc != 3) begin
      fails++; $display("FAIL write_resp: got rv=%b rd=%h cyc=%0d, want 01 0 3", rv, rd, cyc);
    end
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hA5A5_0001) begin
      fails++; $display("FAIL write_hold: got we=%b addr=%h wdata=%h, want 1 20 a5a50001",
                        mem_we, mem_addr, mem_wdata);
    end
    run_txn(0, 1'b0, 32'h20, 32'h0, rd, rv, cyc);
    tests++;
    if (rv !== 2'b01 || rd !== 32'hA5A5_0001 || cyc != 3) begin
      fails++; $display("FAIL readback: got rv=%b rd=%h cyc=%0d, want 01 a5a50001 3", rv, rd, cyc);
    end
  endtask

  task automatic test_fairness;
    logic [1:0] order [4];
    logic [1:0] exp_order [4];
    int n;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    n = 0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (req_ready != '0) begin
        order[n] = req_ready;
        n++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();
    tests++;
    if (n != 4) begin
      fails++; $display("FAIL fair_count: got %0d grants, want 4", n);
    end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (order[i] !== exp_order[i]) begin
        fails++; $display("FAIL fair_order[%0d]: got %b want %b", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int hs_cyc [8];
    int nh;
    int dbl;
    logic prev_req;
    nh = 0; dbl = 0; prev_req = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_ready[0] && nh < 8) begin
        hs_cyc[nh] = c;
        nh++;
      end
      if (mem_req && prev_req) dbl++;
      prev_req = mem_req;
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();
    tests++;
    if (nh != 4) begin
      fails++; $display("FAIL b2b_count: got %0d handshakes, want 4", nh);
    end
    for (int i = 1; i < nh; i++) begin
      tests++;
      if (hs_cyc[i] - hs_cyc[i-1] != 4) begin
        fails++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, hs_cyc[i] - hs_cyc[i-1]);
      end
    end
    tests++;
    if (dbl != 0) begin
      fails++; $display("FAIL b2b_mem_req: got %0d double pulses, want 0", dbl);
    end
  endtask

  task automatic test_stall;
    logic [31:0] rd; logic [1:0] rv; int cyc; int bad;
    extra_lat = 5;
    run_txn(0, 1'b0, 32'h10, 32'h0, rd, rv, cyc);
    extra_lat = 0;
    tests++;
    if (cyc != 8 || rv !== 2'b01 || rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL stall_resp: got cyc=%0d rv=%b rd=%h, want 8 01 deadbeef", cyc, rv, rd);
    end
    bad = 0;
    spur = 1'b1;
    step();
    spur = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid !== 2'b00 || busy !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL spurious_ready: got %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_wait;
    int bad;
    set_port(0, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++; $display("FAIL rst_pre_grant: got %b want 01", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata} !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: got req=%b we=%b addr=%h wdata=%h rv=%b rd=%h busy=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (resp_valid !== 2'b00) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL rst_no_resp: got %0d response cycles, want 0", bad);
    end
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++; $display("FAIL rst_first_winner: got %b want 01", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_write_read();
    test_fairness();
    test_back_to_back();
    test_stall();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
